// File: rtl/nibble_parity_pkg.sv
// Shared types and constants for the nibble parity serial transmitter.
package nibble_parity_pkg;

  localparam int FRAME_BITS = 7;
  localparam int DATA_BITS  = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/parity_generator.sv
// Even-parity (XOR reduction) of one data nibble.
module parity_generator
  import nibble_parity_pkg::*;
(
  input  logic [DATA_BITS-1:0] data,
  output logic                 parity
);

  assign parity = ^data;

endmodule

// File: rtl/nibble_parity_tx.sv
// Serial transmitter: start, 4 data bits LSB first, parity, stop; each bit CLKS_PER_BIT cycles.
// Define ODD_PARITY_EN to send odd parity instead of even parity.
module nibble_parity_tx
  import nibble_parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0] IDX_LAST = 2'(DATA_BITS - 1);

  // Valid/ready: a nibble is accepted on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, and in_valid while busy is simply ignored.
  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [1:0]           bit_idx;
  logic [DATA_BITS-1:0] data_q;
  logic                 xor_par;
  logic                 par_bit;
  logic                 bit_end;
  logic                 done_next;

  parity_generator u_parity (
    .data   (data_q),
    .parity (xor_par)
  );

`ifdef ODD_PARITY_EN
  assign par_bit = ~xor_par;
`else
  assign par_bit = xor_par;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign bit_end  = (cnt == CNT_LAST);

  // frame_done is registered, so raise it on the edge that enters the last stop cycle.
  assign done_next = ((state == STOP) && (int'(cnt) == CLKS_PER_BIT - 2)) ||
                     ((state == PARITY) && bit_end && (CLKS_PER_BIT == 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      data_q     <= '0;
      tx_out     <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_next;
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          if (in_valid && in_ready) begin
            data_q <= data_in;
            state  <= START;
            tx_out <= 1'b0;
            cnt    <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx_out  <= data_q[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
              state   <= PARITY;
              tx_out  <= par_bit;
            end else begin
              bit_idx <= bit_idx + 2'd1;
              tx_out  <= data_q[bit_idx + 2'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            cnt    <= '0;
            state  <= STOP;
            tx_out <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt    <= '0;
            state  <= IDLE;
            tx_out <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule
